// File: rtl/apb_mux_wd_pkg.sv
// Shared types for the APB slave mux: FSM state encoding and the slave-index width helper.
package apb_mux_wd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_SLV = 2'd1,
    ACC_DEF = 2'd2
  } state_e;

  // Width of a slave index; a single-slave mux still carries a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_mux_wd_decode.sv
// Address-window priority decoder: the lowest-numbered matching slave wins.
module apb_mux_wd_decode
  import apb_mux_wd_pkg::*;
#(
  parameter int PADDR_SIZE = 32,
  parameter int SLAVES     = 8,
  parameter int IDX_W      = idx_width(SLAVES)
) (
  input  logic [PADDR_SIZE-1:0] paddr,
  input  logic [PADDR_SIZE-1:0] slv_addr [SLAVES],
  input  logic [PADDR_SIZE-1:0] slv_mask [SLAVES],
  output logic                  hit,
  output logic [IDX_W-1:0]      index
);

  // Scanning downwards lets a lower-index match overwrite a higher one.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if ((paddr & slv_mask[s]) == (slv_addr[s] & slv_mask[s])) begin
        hit   = 1'b1;
        index = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/apb_mux_wd.sv
// APB one-master-to-N-slave mux with default error slave and optional access watchdog.
// Define APB_MUX_WD_TIMEOUT_EN to enable the watchdog that aborts stalled slave accesses.
module apb_mux_wd
  import apb_mux_wd_pkg::*;
#(
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int SLAVES     = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  MST_PSEL,
  input  logic                  MST_PENABLE,
  input  logic [PADDR_SIZE-1:0] MST_PADDR,
  output logic [PDATA_SIZE-1:0] MST_PRDATA,
  output logic                  MST_PREADY,
  output logic                  MST_PSLVERR,
  input  logic [PADDR_SIZE-1:0] slv_addr [SLAVES],
  input  logic [PADDR_SIZE-1:0] slv_mask [SLAVES],
  output logic [SLAVES-1:0]     SLV_PSEL,
  input  logic [PDATA_SIZE-1:0] SLV_PRDATA [SLAVES],
  input  logic [SLAVES-1:0]     SLV_PREADY,
  input  logic [SLAVES-1:0]     SLV_PSLVERR,
  output logic                  err_unmapped,
  output logic                  err_timeout
);

  localparam int IDX_W = idx_width(SLAVES);

  if (SLAVES < 1 || SLAVES > 64 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("apb_mux_wd: SLAVES or TIMEOUT out of range");
  end

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] dec_index;
  logic             dec_hit;
  logic             setup;
  logic             sel_ready;
  logic             complete;
  logic             abort;

  apb_mux_wd_decode #(
    .PADDR_SIZE (PADDR_SIZE),
    .SLAVES     (SLAVES),
    .IDX_W      (IDX_W)
  ) u_decode (
    .paddr    (MST_PADDR),
    .slv_addr (slv_addr),
    .slv_mask (slv_mask),
    .hit      (dec_hit),
    .index    (dec_index)
  );

  assign setup     = MST_PSEL & ~MST_PENABLE;
  assign sel_ready = SLV_PREADY[idx_q];
  assign complete  = (state == ACC_SLV) & MST_PSEL & MST_PENABLE & sel_ready;

`ifdef APB_MUX_WD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd;

  // Abort fires in the stalled cycle that would bring the count up to TIMEOUT.
  assign abort = (state == ACC_SLV) & MST_PSEL & MST_PENABLE & ~sel_ready &
                 (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wd <= '0;
    end else if (state != ACC_SLV || state_nxt == IDLE) begin
      wd <= '0;
    end else if (MST_PENABLE && !sel_ready) begin
      wd <= wd + 1'b1;
    end
  end

  assign err_timeout = abort & ~PRESET;
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = dec_hit ? ACC_SLV : ACC_DEF;
      ACC_SLV: if (!MST_PSEL || complete || abort) state_nxt = IDLE;
      ACC_DEF: if (!MST_PSEL || MST_PENABLE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && setup) idx_q <= dec_index;
    end
  end

  // Outputs are purely combinational so completions add no wait state; reset masks them all.
  always_comb begin
    SLV_PSEL     = '0;
    MST_PREADY   = 1'b0;
    MST_PSLVERR  = 1'b0;
    MST_PRDATA   = '0;
    err_unmapped = 1'b0;
    if (!PRESET) begin
      case (state)
        IDLE: begin
          if (MST_PSEL && dec_hit) SLV_PSEL[dec_index] = 1'b1;
        end
        ACC_SLV: begin
          if (MST_PSEL && !abort) SLV_PSEL[idx_q] = 1'b1;
          if (complete) begin
            MST_PREADY  = 1'b1;
            MST_PSLVERR = SLV_PSLVERR[idx_q];
            MST_PRDATA  = SLV_PRDATA[idx_q];
          end else if (abort) begin
            MST_PREADY  = 1'b1;
            MST_PSLVERR = 1'b1;
          end
        end
        ACC_DEF: begin
          if (MST_PSEL && MST_PENABLE) begin
            MST_PREADY   = 1'b1;
            MST_PSLVERR  = 1'b1;
            err_unmapped = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mux_wd.sv
// Self-checking bench for apb_mux_wd: directed vector table, hand-written corner sequences, random transfers.
module tb_apb_mux_wd;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int NS      = 8;
  localparam int TIMEOUT = 4;

  logic          PCLK;
  logic          PRESET;
  logic          MST_PSEL;
  logic          MST_PENABLE;
  logic [AW-1:0] MST_PADDR;
  logic [DW-1:0] MST_PRDATA;
  logic          MST_PREADY;
  logic          MST_PSLVERR;
  logic [AW-1:0] slv_addr [NS];
  logic [AW-1:0] slv_mask [NS];
  logic [NS-1:0] SLV_PSEL;
  logic [DW-1:0] SLV_PRDATA [NS];
  logic [NS-1:0] SLV_PREADY;
  logic [NS-1:0] SLV_PSLVERR;
  logic          err_unmapped;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  apb_mux_wd #(
    .PADDR_SIZE (AW),
    .PDATA_SIZE (DW),
    .SLAVES     (NS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .MST_PSEL     (MST_PSEL),
    .MST_PENABLE  (MST_PENABLE),
    .MST_PADDR    (MST_PADDR),
    .MST_PRDATA   (MST_PRDATA),
    .MST_PREADY   (MST_PREADY),
    .MST_PSLVERR  (MST_PSLVERR),
    .slv_addr     (slv_addr),
    .slv_mask     (slv_mask),
    .SLV_PSEL     (SLV_PSEL),
    .SLV_PRDATA   (SLV_PRDATA),
    .SLV_PREADY   (SLV_PREADY),
    .SLV_PSLVERR  (SLV_PSLVERR),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [AW-1:0] addr;
    int            waits;
    int            exp_idx;
    logic          b2b;
  } vec_t;

  vec_t vecs [10];

  // Reference decode straight from the window rule: first slave whose masked address matches.
  function automatic int refDecode(input logic [AW-1:0] addr);
    for (int s = 0; s < NS; s++)
      if ((addr & slv_mask[s]) == (slv_addr[s] & slv_mask[s])) return s;
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int idx);
    logic [NS-1:0] one;
    one = 1;
    if (idx < 0) return '0;
    return one << idx;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [NS-1:0] psel, input logic rdy,
                            input logic err, input logic [DW-1:0] data, input logic unm,
                            input logic to, input logic chk_psel);
    if (chk_psel) checkOutput({tag, " SLV_PSEL"}, 64'(SLV_PSEL), 64'(psel));
    checkOutput({tag, " MST_PREADY"},   64'(MST_PREADY),   64'(rdy));
    checkOutput({tag, " MST_PSLVERR"},  64'(MST_PSLVERR),  64'(err));
    checkOutput({tag, " MST_PRDATA"},   64'(MST_PRDATA),   64'(data));
    checkOutput({tag, " err_unmapped"}, 64'(err_unmapped), 64'(unm));
    checkOutput({tag, " err_timeout"},  64'(err_timeout),  64'(to));
  endtask

  task automatic applyStimulus(input logic psel, input logic penable, input logic [AW-1:0] addr);
    @(negedge PCLK);
    MST_PSEL    = psel;
    MST_PENABLE = penable;
    MST_PADDR   = addr;
  endtask

  // Non-target slaves get inverted ready and random data so misrouting shows up.
  task automatic driveSlaves(input int target, input logic rdy, input logic [DW-1:0] data, input logic err);
    for (int s = 0; s < NS; s++) begin
      if (s == target) begin
        SLV_PRDATA[s]  = data;
        SLV_PSLVERR[s] = err;
        SLV_PREADY[s]  = rdy;
      end else begin
        SLV_PRDATA[s]  = $urandom;
        SLV_PSLVERR[s] = 1'($urandom_range(0, 1));
        SLV_PREADY[s]  = (target < 0) ? 1'($urandom_range(0, 1)) : ~rdy;
      end
    end
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, $urandom);
    driveSlaves(-1, 1'b0, '0, 1'b0);
    #2;
    checkCycle({tag, " idle"}, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic runTransfer(input string tag, input logic [AW-1:0] addr, input int waits, input int exp_idx);
    logic [DW-1:0] data;
    logic          err;
    logic [NS-1:0] oh;
    logic          rdy_now;
    data = $urandom;
    err  = 1'($urandom_range(0, 1));
    oh   = onehot(exp_idx);
    applyStimulus(1'b1, 1'b0, addr);
    driveSlaves(exp_idx, 1'b0, data, err);
    #2;
    checkCycle({tag, " setup"}, oh, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= waits + 1; k++) begin
      rdy_now = (k == waits + 1);
      applyStimulus(1'b1, 1'b1, addr);
      driveSlaves(exp_idx, rdy_now, data, err);
      #2;
      if (exp_idx < 0) begin
        checkCycle({tag, " unmapped"}, '0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b1);
        break;
      end
`ifdef APB_MUX_WD_TIMEOUT_EN
      if (!rdy_now && k == TIMEOUT) begin
        checkCycle({tag, " abort"}, oh, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        break;
      end
`endif
      if (rdy_now) checkCycle({tag, " done"}, oh, 1'b1, err, data, 1'b0, 1'b0, 1'b1);
      else         checkCycle({tag, " wait"}, oh, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got still running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int            exp_idx;
    logic [AW-1:0] addr;
    string         tag;

    slv_addr[0] = 32'h0000_1000; slv_mask[0] = 32'hFFFF_F000;
    slv_addr[1] = 32'h0000_0080; slv_mask[1] = 32'hFFFF_FFC0;
    slv_addr[2] = 32'h0000_0040; slv_mask[2] = 32'h0000_00F0;
    slv_addr[3] = 32'h0000_0080; slv_mask[3] = 32'hFFFF_FF80;
    slv_addr[4] = 32'h0000_2000; slv_mask[4] = 32'hFFFF_F000;
    slv_addr[5] = 32'h0000_3000; slv_mask[5] = 32'hFFFF_F000;
    slv_addr[6] = 32'h0000_4000; slv_mask[6] = 32'hFFFF_F000;
    slv_addr[7] = 32'h0000_5000; slv_mask[7] = 32'hFFFF_FF00;

    vecs[0] = '{addr: 32'h0000_0044, waits: 2, exp_idx:  2, b2b: 1'b0};
    vecs[1] = '{addr: 32'h0000_0080, waits: 0, exp_idx:  1, b2b: 1'b0};
    vecs[2] = '{addr: 32'h0000_00C0, waits: 1, exp_idx:  3, b2b: 1'b0};
    vecs[3] = '{addr: 32'h0000_FF00, waits: 0, exp_idx: -1, b2b: 1'b0};
    vecs[4] = '{addr: 32'h0000_1234, waits: 0, exp_idx:  0, b2b: 1'b0};
    vecs[5] = '{addr: 32'h0000_3ABC, waits: 0, exp_idx:  5, b2b: 1'b1};
    vecs[6] = '{addr: 32'h0000_4FFC, waits: 3, exp_idx:  6, b2b: 1'b0};
    vecs[7] = '{addr: 32'h0000_50A0, waits: 1, exp_idx:  7, b2b: 1'b0};
    vecs[8] = '{addr: 32'h0000_2000, waits: 0, exp_idx:  4, b2b: 1'b0};
    vecs[9] = '{addr: 32'h0000_5100, waits: 0, exp_idx: -1, b2b: 1'b0};

    PRESET      = 1'b1;
    MST_PSEL    = 1'b1;
    MST_PENABLE = 1'b0;
    MST_PADDR   = 32'h0000_0044;
    driveSlaves(-1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge PCLK);
    #2;
    checkCycle("reset", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    @(negedge PCLK);
    MST_PSEL = 1'b0;
    PRESET   = 1'b0;
    idleCycle("post-reset");

    // Directed table; b2b entries skip the idle cycle that normally precedes them.
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      if (!vecs[i].b2b) idleCycle(tag);
      runTransfer(tag, vecs[i].addr, vecs[i].waits, vecs[i].exp_idx);
    end
    idleCycle("after table");

    // Stalled slave: aborts at the TIMEOUT-th access cycle with the watchdog, else keeps waiting.
    runTransfer("stall", 32'h0000_0044, 100, 2);
    idleCycle("after stall");
    runTransfer("post-stall", 32'h0000_0080, 0, 1);
    idleCycle("post-stall");

    // Reset pulsed while slave 2 is inserting wait states.
    applyStimulus(1'b1, 1'b0, 32'h0000_0044);
    driveSlaves(2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    #2;
    checkCycle("rst-mid setup", onehot(2), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0044);
    driveSlaves(2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    #2;
    checkCycle("rst-mid wait", onehot(2), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    PRESET = 1'b1;
    #1;
    checkCycle("rst-mid asserted", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge PCLK);
    MST_PSEL    = 1'b0;
    MST_PENABLE = 1'b0;
    #2;
    checkCycle("rst-mid held", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge PCLK);
    PRESET = 1'b0;
    idleCycle("rst-mid released");
    runTransfer("rst-mid next", 32'h0000_0044, 2, 2);

    // Random transfers against the reference decode, with random back-to-back spacing.
    for (int i = 0; i < 40; i++) begin
      addr    = 32'($urandom_range(0, 32'h5FFF));
      exp_idx = refDecode(addr);
      tag     = $sformatf("rnd%0d@%0h", i, addr);
      if ($urandom_range(0, 1) == 1) idleCycle(tag);
      runTransfer(tag, addr, $urandom_range(0, 3), exp_idx);
    end
    idleCycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
